// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the RAM slave: transfer encodings, response codes,
// slave state encoding and the address/size legality check.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_e;

  localparam logic [7:0] REGION_RAM = 8'hB0;

  // Unsupported sizes and misaligned halfword/word accesses are rejected.
  function automatic logic size_align_err(input logic [2:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      HSIZE_BYTE: err = 1'b0;
      HSIZE_HALF: err = addr_lo[0];
      HSIZE_WORD: err = (addr_lo != 2'b00);
      default:    err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering between the 32-bit RAM word and right-justified AHB data:
// write byte-enables/replicated write word, and extracted, extended read data.
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and sign/zero extension for each supported size
  always_comb begin
    byte_en = 4'b0000;
    wr_word = 32'h0000_0000;
    rd_word = 32'h0000_0000;
    byte_s  = 8'h00;
    half_s  = 16'h0000;
    case (size)
      HSIZE_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wr_word = {4{wdata[7:0]}};
        byte_s  = ram_word[{addr_lo, 3'b000} +: 8];
        rd_word = {{24{is_signed & byte_s[7]}}, byte_s};
      end
      HSIZE_HALF: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
        half_s  = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];
        rd_word = {{16{is_signed & half_s[15]}}, half_s};
      end
      HSIZE_WORD: begin
        byte_en = 4'b1111;
        wr_word = wdata;
        rd_word = ram_word;
      end
      default: begin
        byte_en = 4'b0000;
        wr_word = 32'h0000_0000;
        rd_word = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM slave with a fixed number of wait states per OKAY transfer and a
// two-cycle ERROR response for out-of-region, out-of-range or misaligned accesses.
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter int         WAIT_CYCLES = 2,
  parameter int         DEPTH_WORDS = 1024,
  parameter logic [7:0] REGION      = REGION_RAM
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic        is_signed,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH_WORDS);
  localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 2'(WAIT_CYCLES - 1) : 2'd0;

  slave_state_e  state_r, state_s;
  logic [1:0]    cnt_r, cnt_s;
  logic [AW+1:0] addr_r;
  logic          wr_r;
  logic [2:0]    size_r;
  logic          signed_r;
  logic          hready_r, hready_s;
  logic          hresp_r, hresp_s;
  logic [31:0]   hrdata_r, hrdata_s;
  logic [31:0]   mem_r [DEPTH_WORDS];

  logic          accept_s, bus_err_s, wr_commit_s;
  logic [AW-1:0] bus_idx_s, wr_idx_s, rd_idx_s;
  logic [3:0]    wr_be_s;
  logic [31:0]   wr_word_s;
  logic          rd_wr_s, rd_signed_s;
  logic [2:0]    rd_size_s;
  logic [1:0]    rd_lo_s;
  logic [31:0]   rd_raw_s, rd_ext_s;
  logic [31:0]   wr_rd_unused_s, rd_wr_unused_s;
  logic [3:0]    rd_be_unused_s;
  logic          unused_s;

  assign unused_s    = ^{hprot, htrans[0], haddr};
  assign accept_s    = hsel & htrans[1] & hready_r & ((state_r == ST_IDLE) | (state_r == ST_DATA));
  assign bus_idx_s   = haddr[AW+1:2];
  assign bus_err_s   = (haddr[31:24] != REGION) | ({1'b0, bus_idx_s} >= DEPTH_L) |
                       size_align_err(hsize, haddr[1:0]);
  assign wr_idx_s    = addr_r[AW+1:2];
  assign wr_commit_s = (state_r == ST_DATA) & wr_r;

  // Read attributes come from the bus when DATA follows acceptance directly, else from capture
  always_comb begin
    if (state_r == ST_WAIT) begin
      rd_wr_s     = wr_r;
      rd_size_s   = size_r;
      rd_lo_s     = addr_r[1:0];
      rd_signed_s = signed_r;
      rd_idx_s    = wr_idx_s;
    end else begin
      rd_wr_s     = hwrite;
      rd_size_s   = hsize;
      rd_lo_s     = haddr[1:0];
      rd_signed_s = is_signed;
      rd_idx_s    = bus_idx_s;
    end
  end

  // Forward bytes of a write committing this edge into a back-to-back read of the same word
  always_comb begin
    rd_raw_s = mem_r[rd_idx_s];
    for (int b = 0; b < 4; b++) begin
      if (wr_commit_s && (rd_idx_s == wr_idx_s) && wr_be_s[b]) begin
        rd_raw_s[8*b +: 8] = wr_word_s[8*b +: 8];
      end else begin
        rd_raw_s[8*b +: 8] = mem_r[rd_idx_s][8*b +: 8];
      end
    end
  end

  ahb_lane_align u_wr_align (
    .size      (size_r),
    .addr_lo   (addr_r[1:0]),
    .is_signed (1'b0),
    .ram_word  (32'h0000_0000),
    .wdata     (hwdata),
    .byte_en   (wr_be_s),
    .wr_word   (wr_word_s),
    .rd_word   (wr_rd_unused_s)
  );

  ahb_lane_align u_rd_align (
    .size      (rd_size_s),
    .addr_lo   (rd_lo_s),
    .is_signed (rd_signed_s),
    .ram_word  (rd_raw_s),
    .wdata     (32'h0000_0000),
    .byte_en   (rd_be_unused_s),
    .wr_word   (rd_wr_unused_s),
    .rd_word   (rd_ext_s)
  );

  // Next-state and wait counter
  always_comb begin
    state_s = state_r;
    cnt_s   = 2'd0;
    case (state_r)
      ST_IDLE, ST_DATA: begin
        if (accept_s) begin
          if (bus_err_s) begin
            state_s = ST_ERR1;
          end else if (HAS_WAIT) begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_LOAD;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 2'd0) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = cnt_r - 2'd1;
        end
      end
      ST_ERR1: state_s = ST_ERR2;
      ST_ERR2: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = HRESP_OKAY;
    hrdata_s = 32'h0000_0000;
    case (state_s)
      ST_WAIT: hready_s = 1'b0;
      ST_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = HRESP_ERROR;
      end
      ST_ERR2: hresp_s = HRESP_ERROR;
      ST_DATA: begin
        if (!rd_wr_s) begin
          hrdata_s = rd_ext_s;
        end else begin
          hrdata_s = 32'h0000_0000;
        end
      end
      default: hready_s = 1'b1;
    endcase
  end

  // State, counter, response and address-phase capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 2'd0;
      hready_r <= 1'b1;
      hresp_r  <= HRESP_OKAY;
      hrdata_r <= 32'h0000_0000;
      addr_r   <= '0;
      wr_r     <= 1'b0;
      size_r   <= 3'b000;
      signed_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      hready_r <= hready_s;
      hresp_r  <= hresp_s;
      hrdata_r <= hrdata_s;
      if (accept_s) begin
        addr_r   <= haddr[AW+1:0];
        wr_r     <= hwrite;
        size_r   <= hsize;
        signed_r <= is_signed;
      end
    end
  end

  // RAM array: no reset, byte-enabled write at the end of a write data phase
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_r[wr_idx_s][8*b +: 8] <= wr_word_s[8*b +: 8];
        end
      end
    end
  end

  assign hready = hready_r;
  assign hresp  = hresp_r;
  assign hrdata = hrdata_r;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Scoreboard bench for ahb_ram_slave: a WAIT_CYCLES=2 instance for the main tests and
// a WAIT_CYCLES=0 instance for back-to-back pipelined transfers.
module tb_ahb_ram_slave;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hsel, hwrite, is_signed, mode;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hsel_a, hsel_b, hready_a, hready_b, hresp_a, hresp_b;
  logic [31:0] hrdata_a, hrdata_b;
  logic        m_hready, m_hresp;
  logic [31:0] m_hrdata;

  always #5 clk = ~clk;

  assign hsel_a   = hsel & ~mode;
  assign hsel_b   = hsel & mode;
  assign m_hready = mode ? hready_b : hready_a;
  assign m_hresp  = mode ? hresp_b  : hresp_a;
  assign m_hrdata = mode ? hrdata_b : hrdata_a;

  ahb_ram_slave #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024), .REGION(8'hB0)) u_dut (
    .clk(clk), .reset_n(reset_n), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .is_signed(is_signed),
    .hwdata(hwdata), .hrdata(hrdata_a), .hready(hready_a), .hresp(hresp_a));

  ahb_ram_slave #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024), .REGION(8'hB0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .is_signed(is_signed),
    .hwdata(hwdata), .hrdata(hrdata_b), .hready(hready_b), .hresp(hresp_b));

  typedef struct {
    logic [31:0] data;
    logic        resp;
    int          waits;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [2:0]  sz;
    logic        sg;
    logic [31:0] wd;
    logic [31:0] ed;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic acc_seen = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // acceptance as seen by the slave at this edge
  always @(posedge clk) acc_seen <= reset_n && hsel && htrans[1] && m_hready;

  initial begin : monitor
    bit       in_dp;
    int       lows;
    logic [1:0] low_resp;
    logic     low_data_nz;
    exp_t     e;
    in_dp = 1'b0; lows = 0; low_resp = 2'b00; low_data_nz = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_dp = 1'b0;
      end else begin
        if (acc_seen) begin
          in_dp = 1'b1; lows = 0; low_resp = 2'b00; low_data_nz = 1'b0;
        end
        if (in_dp) begin
          if (!m_hready) begin
            lows++;
            if (m_hresp) low_resp[1] = 1'b1; else low_resp[0] = 1'b1;
            if (m_hrdata != 32'h0) low_data_nz = 1'b1;
          end else begin
            if (sb_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_completion: got a data phase, expected none");
            end else begin
              e = sb_q.pop_front();
              check({e.name, ".hrdata"}, m_hrdata, e.data);
              check({e.name, ".hresp"}, {31'h0, m_hresp}, {31'h0, e.resp});
              check({e.name, ".waits"}, lows, e.waits);
              if (e.waits > 0) begin
                check({e.name, ".low_hresp"}, {30'h0, low_resp}, e.resp ? 32'h2 : 32'h1);
                check({e.name, ".low_hrdata"}, {31'h0, low_data_nz}, 32'h0);
              end
            end
            in_dp = 1'b0;
          end
        end
      end
    end
  end

  task automatic xfer(input string nm, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic sg, input logic [31:0] wd, input logic [31:0] exp_d,
                      input logic exp_r, input int exp_w);
    int budget;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; is_signed = sg;
    sb_q.push_back('{data: exp_d, resp: exp_r, waits: exp_w, name: nm});
    budget = 0;
    #1;
    while (!m_hready && budget < 20) begin @(negedge clk); #1; budget++; end
    if (budget >= 20) begin n_checks++; n_fail++; $display("FAIL %s.accept_timeout: got hready=0, expected 1", nm); end
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    budget = 0;
    #1;
    while (!m_hready && budget < 20) begin @(negedge clk); #1; budget++; end
    if (budget >= 20) begin n_checks++; n_fail++; $display("FAIL %s.done_timeout: got hready=0, expected 1", nm); end
    if (exp_r) @(negedge clk);
  endtask

  initial begin : driver
    vec_t pv[7];
    int   budget;
    pv[0] = '{32'hB000_0040, 1'b1, 3'd2, 1'b0, 32'h1122_3344, 32'h0000_0000};
    pv[1] = '{32'hB000_0040, 1'b0, 3'd2, 1'b0, 32'h0000_0000, 32'h1122_3344};
    pv[2] = '{32'hB000_0041, 1'b1, 3'd0, 1'b0, 32'h0000_00AB, 32'h0000_0000};
    pv[3] = '{32'hB000_0040, 1'b0, 3'd1, 1'b1, 32'h0000_0000, 32'hFFFF_AB44};
    pv[4] = '{32'hB000_0043, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 32'h0000_0011};
    pv[5] = '{32'hB000_0042, 1'b1, 3'd1, 1'b0, 32'h0000_BEEF, 32'h0000_0000};
    pv[6] = '{32'hB000_0040, 1'b0, 3'd2, 1'b0, 32'h0000_0000, 32'hBEEF_AB44};

    mode = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'b000;
    hprot = 4'b0011; is_signed = 1'b0; hwdata = 32'h0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.hready", {31'h0, hready_a}, 32'h1);
    check("reset.hresp", {31'h0, hresp_a}, 32'h0);
    check("reset.hrdata", hrdata_a, 32'h0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    xfer("sw_deadbeef", 32'hB000_0010, 1'b1, 3'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    xfer("lw_deadbeef", 32'hB000_0010, 1'b0, 3'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    xfer("sw_80ff7f01", 32'hB000_0010, 1'b1, 3'd2, 1'b0, 32'h80FF_7F01, 32'h0, 1'b0, 2);
    xfer("lb_s_lane3", 32'hB000_0013, 1'b0, 3'd0, 1'b1, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    xfer("lbu_lane3", 32'hB000_0013, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0000_0080, 1'b0, 2);
    xfer("lb_s_lane2", 32'hB000_0012, 1'b0, 3'd0, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0, 2);
    xfer("lb_s_lane0", 32'hB000_0010, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0000_0001, 1'b0, 2);
    xfer("lhu_lo", 32'hB000_0010, 1'b0, 3'd1, 1'b0, 32'h0, 32'h0000_7F01, 1'b0, 2);
    xfer("lh_s_hi", 32'hB000_0012, 1'b0, 3'd1, 1'b1, 32'h0, 32'hFFFF_80FF, 1'b0, 2);
    xfer("sw_aaaa", 32'hB000_0020, 1'b1, 3'd2, 1'b0, 32'hAAAA_AAAA, 32'h0, 1'b0, 2);
    xfer("sh_1234", 32'hB000_0022, 1'b1, 3'd1, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 2);
    xfer("lw_after_sh", 32'hB000_0020, 1'b0, 3'd2, 1'b0, 32'h0, 32'h1234_AAAA, 1'b0, 2);
    xfer("err_lw_misal", 32'hB000_0002, 1'b0, 3'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    xfer("err_lw_region", 32'hA000_0000, 1'b0, 3'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    xfer("err_sh_misal", 32'hB000_0021, 1'b1, 3'd1, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1, 1);
    xfer("err_size3", 32'hB000_0020, 1'b1, 3'd3, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1);
    xfer("err_sw_region", 32'hC000_0020, 1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    xfer("lw_after_err", 32'hB000_0020, 1'b0, 3'd2, 1'b0, 32'h0, 32'h1234_AAAA, 1'b0, 2);

    // write aborted by reset during its wait states
    hsel = 1'b1; htrans = 2'b10; haddr = 32'hB000_0020; hwrite = 1'b1; hsize = 3'd2; is_signed = 1'b0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h5555_5555;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid.hready", {31'h0, hready_a}, 32'h1);
    check("rst_mid.hresp", {31'h0, hresp_a}, 32'h0);
    check("rst_mid.hrdata", hrdata_a, 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    xfer("lw_after_rst", 32'hB000_0020, 1'b0, 3'd2, 1'b0, 32'h0, 32'h1234_AAAA, 1'b0, 2);

    // zero-wait instance: one NONSEQ per cycle
    @(negedge clk);
    mode = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      hsel = 1'b1; htrans = 2'b10; haddr = pv[i].a; hwrite = pv[i].wr; hsize = pv[i].sz;
      is_signed = pv[i].sg;
      if (i > 0) hwdata = pv[i-1].wd;
      sb_q.push_back('{data: pv[i].ed, resp: 1'b0, waits: 0, name: $sformatf("pipe%0d", i)});
      @(negedge clk); #1;
    end
    hsel = 1'b0; htrans = 2'b00; hwdata = pv[6].wd;

    budget = 0;
    while (sb_q.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    check("scoreboard_drained", sb_q.size(), 32'h0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_ram_slave.md
AHB_RAM_SLAVE -- requirements
Module: ahb_ram_slave

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of hready-low cycles inserted in every OKAY data phase (legal range 0..3).
REQ-002 Parameter DEPTH_WORDS, default 1024: 32-bit words of internal RAM; index is haddr[log2(DEPTH_WORDS)+1:2].
REQ-003 Parameter REGION, default 8'hB0: required value of haddr[31:24].
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 hsel  input  1  slave select from the address decoder.
REQ-007 haddr  input  32  address-phase address.
REQ-008 htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-009 hwrite  input  1  1 = write, 0 = read.
REQ-010 hsize  input  3  000 byte, 001 halfword, 010 word; any other value is an error.
REQ-011 hprot  input  4  accepted and ignored.
REQ-012 is_signed  input  1  address-phase flag: sign-extend a byte/halfword read.
REQ-013 hwdata  input  32  data-phase write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-014 hrdata  output  32  read data, right-justified and extended per the captured is_signed.
REQ-015 hready  output  1  1 = current data phase completes this cycle.
REQ-016 hresp  output  1  0 OKAY, 1 ERROR.

Function
REQ-017 A transfer is accepted at a posedge when hsel=1, htrans[1]=1 and hready=1; haddr, hwrite, hsize and is_signed are registered at that edge.
REQ-018 IDLE or BUSY while selected, or any cycle with hsel=0, gets a zero-wait OKAY (hready=1, hresp=0) and has no RAM effect.
REQ-019 States: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-020 IDLE -> WAIT on acceptance when WAIT_CYCLES>0; IDLE -> DATA when WAIT_CYCLES=0; IDLE -> ERR1 when the accepted transfer is erroneous.
REQ-021 WAIT: hready=0, hresp=0; a down-counter loaded with WAIT_CYCLES-1 moves to DATA on reaching 0.
REQ-022 DATA: hready=1, hresp=0.
REQ-023 DATA, read: hrdata is valid in that cycle.
REQ-024 DATA, write: at the DATA->next edge, hwdata is written using the byte-enables derived from the captured hsize and haddr[1:0].
REQ-025 DATA exit: a new acceptance in DATA follows the REQ-020 rules; otherwise the state goes to IDLE.
REQ-026 Erroneous transfer, any one of:
- haddr[31:24] != REGION;
- word index >= DEPTH_WORDS;
- halfword with haddr[0]=1;
- word with haddr[1:0]!=0;
- hsize > 010.
REQ-027 ERR1: hready=0, hresp=1. ERR2: hready=1, hresp=1; ERR2 -> IDLE, and an acceptance in ERR2 is ignored.
REQ-028 An erroneous transfer never modifies RAM, and hrdata=0 during ERR1 and ERR2.
REQ-029 Read extract: a byte comes from lane haddr[1:0] and a halfword from lane haddr[1].
REQ-030 Read extension: sign-extend when the captured is_signed=1, otherwise zero-extend.
REQ-031 hrdata=0 in every state other than read DATA.
REQ-032 Read-after-write to the same word in back-to-back transfers returns the newly written value.
REQ-033 RAM contents are undefined after power-up and are not cleared by reset.

Reset
REQ-034 While reset_n=0:
- state=IDLE, counter=0;
- hready=1, hresp=0, hrdata=0;
- captured address-phase registers cleared.
REQ-035 Reset asserted mid-transfer (WAIT or DATA) aborts the transfer, and no write is committed.
REQ-036 The first acceptance can occur on the first posedge after reset_n rises.

Structure
REQ-037 Shared package ahb_pkg holds:
- htrans and hsize enums;
- HRESP_OKAY and HRESP_ERROR constants;
- the slave state enum;
- REGION_RAM = 8'hB0.
REQ-038 One combinational sub-module, ahb_lane_align:
- inputs: size, addr[1:0], signed flag, RAM word, hwdata;
- outputs: 4-bit byte-enable, aligned write word, extended read word.

Verification
REQ-039 Word write 0xB0000010 <- 0xDEADBEEF, then LW at the same address (WAIT_CYCLES=2) -> each transfer shows 2 cycles hready=0 then hready=1; hrdata=0xDEADBEEF.
REQ-040 Byte read from 0xB0000013 with RAM word 0x80FF7F01 -> is_signed=1 gives hrdata=0xFFFFFF80; is_signed=0 gives hrdata=0x00000080.
REQ-041 SH 0x1234 to 0xB0000022 over word 0xAAAAAAAA -> subsequent LW returns 0x1234AAAA.
REQ-042 LW from 0xB0000002, and separately from 0xA0000000 -> ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); RAM unchanged.
REQ-043 Write accepted, reset_n pulsed low during WAIT -> outputs return to reset values immediately; readback shows the old word.
REQ-044 WAIT_CYCLES=0: NONSEQ issued on consecutive cycles -> hready stays 1 and each data phase completes in one cycle.
